mul_issue: RTL
==============

MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the operand FIFO depth in entries (power of two, at least 2).
REQ-002 The block SHALL have parameter TIMEOUT, default 33, meaning the maximum number of cycles to wait for mul_valid after start is raised.
REQ-003 The block SHALL have parameter GAP, default 2, meaning the minimum number of cycles mul_start is held low between operations.
REQ-004 clock  in  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  an operand pair is offered.
REQ-007 in_ready  out  1  the FIFO can accept a pair.
REQ-008 in_mlier  in  32  signed multiplier.
REQ-009 in_mcand  in  32  signed multiplicand.
REQ-010 mul_start  out  1  to the multiplier; held high for the whole operation.
REQ-011 mul_mlier  out  32  operand to the multiplier; stable while mul_start is high.
REQ-012 mul_mcand  out  32  operand to the multiplier; stable while mul_start is high.
REQ-013 mul_prodt  in  64  signed product from the multiplier.
REQ-014 mul_valid  in  1  single-cycle pulse from the multiplier marking mul_prodt valid.
REQ-015 out_valid  out  1  out_prodt holds a result.
REQ-016 out_ready  in  1  the consumer accepts the result.
REQ-017 out_prodt  out  64  registered product.
REQ-018 timeout_err  out  1  sticky flag: an operation timed out.
REQ-019 done_cnt  out  16  count of results delivered.

Function
REQ-020 The input side SHALL accept a pair when in_valid and in_ready are both high on a rising edge; in_ready SHALL be high exactly when the FIFO is not full.
REQ-021 When the FIFO is full, in_ready SHALL be low and offered pairs SHALL NOT be written; a pop and a push in the same cycle while full SHALL NOT be possible because in_ready is low.
REQ-022 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and the FIFO pointers SHALL wrap modulo DEPTH.
REQ-023 The FSM SHALL have four states: IDLE, RUN, HOLD, GAP.
REQ-024 IDLE SHALL move to RUN when the FIFO is non-empty and out_valid is 0, or out_valid is 1 with out_ready 1; on entry it SHALL pop the head into mul_mlier/mul_mcand and raise mul_start.
REQ-025 In RUN, mul_start SHALL remain 1 and the operands SHALL be held unchanged, while wait_cnt counts from 1.
REQ-026 On mul_valid in RUN, the block SHALL capture mul_prodt into out_prodt, set out_valid, drop mul_start the next cycle, and go to GAP.
REQ-027 In RUN, if wait_cnt exceeds TIMEOUT without mul_valid, the block SHALL set timeout_err, discard the operation (no out_valid), drop mul_start, and go to GAP.
REQ-028 GAP SHALL hold mul_start low for GAP cycles, then go to IDLE.
REQ-029 HOLD is entered from GAP-exit when out_valid is 1 and out_ready is 0; it SHALL go to IDLE when out_ready is 1.
REQ-030 A result SHALL transfer when out_valid and out_ready are both high; out_valid SHALL clear the next cycle unless a new capture coincides, and done_cnt SHALL increment by 1 and wrap at 0xFFFF->0.
REQ-031 mul_valid outside RUN SHALL be ignored.
REQ-032 timeout_err SHALL clear only on reset.
REQ-033 Latency SHALL be 1 cycle from a FIFO push to the earliest mul_start, and 1 cycle from mul_valid to out_valid.
REQ-034 Products SHALL pass through unmodified, 64-bit two's complement.

Reset
REQ-035 While reset_n is 0 the block SHALL asynchronously force state IDLE, FIFO empty, in_ready=1, mul_start=0, mul_mlier=0, mul_mcand=0, out_valid=0, out_prodt=0, timeout_err=0, done_cnt=0.
REQ-036 Reset asserted mid-operation SHALL abort the operation with no result and drop mul_start immediately; FIFO contents SHALL be lost.

Verification
REQ-037 Single op: push (0x7fffffff, 0x7fffffff), out_ready=1 -> out_prodt=0x3FFFFFFF00000001, done_cnt=1, mul_start low for at least 2 cycles afterwards.
REQ-038 Sign cases: push (0xffffffff,0xffffffff), (0x80000000,0x80000000), (0x00000001,0x80000000) back-to-back -> results in order 0x0000000000000001, 0x4000000000000000, 0xFFFFFFFF80000000.
REQ-039 Backpressure: out_ready=0, push 5 pairs -> in_ready drops after the FIFO fills, at most one result pending, no loss; release out_ready -> all 5 results in order, done_cnt=5.
REQ-040 Timeout: the multiplier never asserts mul_valid -> timeout_err=1 after 34 cycles in RUN, no out_valid, and the next queued op still issues.
REQ-041 Reset mid-RUN: reset_n=0 during an operation -> all outputs at reset values immediately; a late mul_valid after reset is ignored.
REQ-042 Zero: push (0x80000000, 0x00000000) -> out_prodt=0x0000000000000000.

Source files
------------

// File: rtl/mul_issue.sv
// mul_issue: operand FIFO in front of a handshaked multiplier. Pairs are
// queued, issued one at a time with mul_start held for the whole operation,
// and the product is registered for a valid/ready consumer. A watchdog drops
// operations the multiplier never answers and leaves a sticky error flag.
module mul_issue #(
    parameter int DEPTH   = 4,   // FIFO entries, power of two, >= 2
    parameter int TIMEOUT = 33,  // cycles to wait for mul_valid
    parameter int GAP     = 2    // minimum mul_start low cycles between ops
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_mlier,
    input  logic [31:0] in_mcand,
    output logic        mul_start,
    output logic [31:0] mul_mlier,
    output logic [31:0] mul_mcand,
    input  logic [63:0] mul_prodt,
    input  logic        mul_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_prodt,
    output logic        timeout_err,
    output logic [15:0] done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 2);
    localparam int GW = $clog2(GAP + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic            mul_start_q, mul_start_d;
    logic [31:0]     mlier_q, mlier_d;
    logic [31:0]     mcand_q, mcand_d;
    logic            out_valid_q, out_valid_d;
    logic [63:0]     out_prodt_q, out_prodt_d;
    logic            timeout_err_q, timeout_err_d;
    logic [15:0]     done_cnt_q, done_cnt_d;

    logic [63:0]     fifo_mem [DEPTH];
    logic [63:0]     head;
    logic            push;
    logic            pop;
    logic            xfer;

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = fifo_mem[rd_ptr_q];
    assign xfer     = out_valid_q && out_ready;

    // FIFO storage: written on every accepted pair.
    // NOTE: the data array has no reset; occupancy and pointers are reset,
    // so stale entries are never read and the array maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {in_mlier, in_mcand};
        end
    end

    // Next-state logic for the issue FSM, output registers and FIFO pointers.
    // NOTE: every _d signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        mul_start_d   = mul_start_q;
        mlier_d       = mlier_q;
        mcand_d       = mcand_q;
        out_valid_d   = out_valid_q;
        out_prodt_d   = out_prodt_q;
        timeout_err_d = timeout_err_q;
        done_cnt_d    = done_cnt_q;
        pop           = 1'b0;

        // A consumed result clears unless a capture below refills it.
        if (xfer) begin
            out_valid_d = 1'b0;
            done_cnt_d  = done_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                // Issue only when the result register is free or draining now.
                if ((count_q != '0) && (!out_valid_q || out_ready)) begin
                    pop         = 1'b1;
                    mlier_d     = head[63:32];
                    mcand_d     = head[31:0];
                    mul_start_d = 1'b1;
                    wait_cnt_d  = WW'(1);
                    state_d     = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mul_valid) begin
                    out_prodt_d = mul_prodt;
                    out_valid_d = 1'b1;
                    mul_start_d = 1'b0;
                    gap_cnt_d   = GW'(1);
                    state_d     = ST_GAP;
                end else if (wait_cnt_q > WW'(TIMEOUT)) begin
                    timeout_err_d = 1'b1;
                    mul_start_d   = 1'b0;
                    gap_cnt_d     = GW'(1);
                    state_d       = ST_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q >= GW'(GAP)) begin
                    state_d = (out_valid_q && !out_ready) ? ST_HOLD : ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of the others, independent of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            wait_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            mul_start_q   <= 1'b0;
            mlier_q       <= '0;
            mcand_q       <= '0;
            out_valid_q   <= 1'b0;
            out_prodt_q   <= '0;
            timeout_err_q <= 1'b0;
            done_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            wait_cnt_q    <= wait_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            mul_start_q   <= mul_start_d;
            mlier_q       <= mlier_d;
            mcand_q       <= mcand_d;
            out_valid_q   <= out_valid_d;
            out_prodt_q   <= out_prodt_d;
            timeout_err_q <= timeout_err_d;
            done_cnt_q    <= done_cnt_d;
        end
    end

    assign mul_start   = mul_start_q;
    assign mul_mlier   = mlier_q;
    assign mul_mcand   = mcand_q;
    assign out_valid   = out_valid_q;
    assign out_prodt   = out_prodt_q;
    assign timeout_err = timeout_err_q;
    assign done_cnt    = done_cnt_q;

endmodule
